// File: rtl/eln_seq.sv
// Multi-cycle fixed-point natural logarithm: normalise x = m*2^k, then shrink ln(m)
// by greedy multiplicative normalisation with one ln(1+2^-i) table entry per cycle.
module eln_seq #(
  parameter int unsigned TOTAL_BITS      = 32,
  parameter int unsigned FRACTIONAL_BITS = 16,
  parameter int unsigned ITERATIONS      = 16,
  parameter int unsigned GUARD_BITS      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] out,
  output logic                  domain_err
);

  localparam int unsigned FG  = FRACTIONAL_BITS + GUARD_BITS;
  localparam int unsigned W   = TOTAL_BITS + GUARD_BITS + 2;
  localparam int unsigned PW  = $clog2(TOTAL_BITS);
  localparam int unsigned KW  = $clog2(TOTAL_BITS + FRACTIONAL_BITS + 1) + 1;
  localparam int unsigned IW  = $clog2(ITERATIONS + 1);
  localparam int unsigned SHR = (TOTAL_BITS >= FG) ? TOTAL_BITS - FG : 0;
  localparam int unsigned SHL = (FG > TOTAL_BITS) ? FG - TOTAL_BITS : 0;

  // ln(1+2^-i) scaled by 2^FG and rounded; i=0 yields ln2 via -ln(1-1/2).
  function automatic longint ln_fixed(input int i);
    longint s;
    longint term;
    int     sh;
    s = 0;
    for (int n = 1; n <= 60; n++) begin
      sh = (i == 0) ? 60 - n : 60 - n * i;
      if (sh >= 0) begin
        term = (longint'(1) << sh) / longint'(n);
        if ((i != 0) && (n % 2 == 0)) s = s - term;
        else                          s = s + term;
      end
    end
    return (s + (longint'(1) << (59 - int'(FG)))) >>> (60 - int'(FG));
  endfunction

  localparam logic        [W-1:0]          ONE     = W'(1) << FG;
  localparam logic signed [W-1:0]          HALF    = W'((64'd1 << GUARD_BITS) >> 1);
  localparam logic signed [W-1:0]          LN2     = W'(ln_fixed(0));
  localparam logic        [TOTAL_BITS-1:0] NEG_MIN = TOTAL_BITS'(1) << (TOTAL_BITS - 1);

  typedef enum logic [2:0] {IDLE, NORM, ITER, FIN, DONE} state_t;

  logic [W-1:0] ln_tab [ITERATIONS+1];

  for (genvar g = 0; g <= ITERATIONS; g++) begin : g_tab
    localparam logic [W-1:0] LN_I = W'(ln_fixed(g));
    assign ln_tab[g] = LN_I;
  end

  state_t                 state, state_nxt;
  logic [TOTAL_BITS-1:0]  x_hold, x_hold_nxt;
  logic [W-1:0]           m, m_nxt;
  logic signed [W-1:0]    acc, acc_nxt;
  logic signed [KW-1:0]   k, k_nxt;
  logic                   err, err_nxt;
  logic [IW-1:0]          iter, iter_nxt;
  logic [TOTAL_BITS-1:0]  out_nxt;
  logic                   out_valid_nxt, in_ready_nxt, domain_err_nxt;

  logic [PW-1:0]          msb;
  logic [TOTAL_BITS-1:0]  xs;
  logic [W-1:0]           t;
  logic signed [W-1:0]    k_ext;

  // Next-state and datapath updates for every phase of the computation.
  always_comb begin
    state_nxt      = state;
    x_hold_nxt     = x_hold;
    m_nxt          = m;
    acc_nxt        = acc;
    k_nxt          = k;
    err_nxt        = err;
    iter_nxt       = iter;
    out_nxt        = out;
    out_valid_nxt  = out_valid;
    in_ready_nxt   = in_ready;
    domain_err_nxt = domain_err;
    msb            = '0;
    xs             = '0;
    t              = m + (m >> iter);
    k_ext          = W'(k);

    case (state)
      IDLE: begin
        if (in_valid) begin
          x_hold_nxt   = x;
          in_ready_nxt = 1'b0;
          state_nxt    = NORM;
        end
      end
      NORM: begin
        for (int b = 0; b < int'(TOTAL_BITS); b++) begin
          if (x_hold[b]) msb = PW'(b);
        end
        // Place the leading one at weight 0.5 in the FG-fraction m register.
        xs       = x_hold << (PW'(TOTAL_BITS - 1) - msb);
        iter_nxt = IW'(1);
        acc_nxt  = '0;
        if ($signed(x_hold) <= 0) begin
          err_nxt = 1'b1;
        end else begin
          err_nxt = 1'b0;
          k_nxt   = KW'(msb) - KW'(FRACTIONAL_BITS - 1);
          m_nxt   = (W'(xs) >> SHR) << SHL;
        end
        state_nxt = ITER;
      end
      ITER: begin
        if (t <= ONE) begin
          m_nxt   = t;
          acc_nxt = acc - $signed(ln_tab[iter]);
        end
        if (iter == IW'(ITERATIONS)) state_nxt = FIN;
        else                         iter_nxt  = iter + IW'(1);
      end
      FIN: begin
        if (err) begin
          out_nxt        = NEG_MIN;
          domain_err_nxt = 1'b1;
        end else begin
          out_nxt        = TOTAL_BITS'((acc + k_ext * LN2 + HALF) >>> GUARD_BITS);
          domain_err_nxt = 1'b0;
        end
        out_valid_nxt = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        in_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      x_hold     <= '0;
      m          <= '0;
      acc        <= '0;
      k          <= '0;
      err        <= 1'b0;
      iter       <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      domain_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      x_hold     <= x_hold_nxt;
      m          <= m_nxt;
      acc        <= acc_nxt;
      k          <= k_nxt;
      err        <= err_nxt;
      iter       <= iter_nxt;
      out        <= out_nxt;
      out_valid  <= out_valid_nxt;
      in_ready   <= in_ready_nxt;
      domain_err <= domain_err_nxt;
    end
  end

endmodule

// File: tb/tb_eln_seq.sv
// Bench for eln_seq: vector table plus random sweep against a real-valued ln model,
// with hand-written sequences for backpressure, mid-computation reset and back-to-back use.
module tb_eln_seq;

  localparam int unsigned TOTAL = 32;
  localparam int unsigned FRAC  = 16;
  localparam int          LAT   = 18;
  localparam int          TOL   = 4;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, domain_err;
  logic [31:0] x, out;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eln_seq #(.TOTAL_BITS(TOTAL), .FRACTIONAL_BITS(FRAC), .ITERATIONS(16), .GUARD_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .domain_err(domain_err));

  typedef struct {
    string       name;
    logic [31:0] xv;
    int          exp_out;
    logic        exp_err;
    int          tol;
  } vec_t;

  vec_t vt[$];

  // Reference: round(ln(x / 2^F) * 2^F) computed in real arithmetic.
  function automatic int ref_ln(input logic [31:0] xv);
    real r;
    r = xv;
    r = $ln(r / 65536.0) * 65536.0;
    return $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] xv);
    vec_t v;
    v.name = nm;
    v.xv   = xv;
    if ($signed(xv) <= 0) begin
      v.exp_out = 32'h8000_0000;
      v.exp_err = 1'b1;
      v.tol     = 0;
    end else begin
      v.exp_out = ref_ln(xv);
      v.exp_err = 1'b0;
      v.tol     = TOL;
    end
    return v;
  endfunction

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic chk_tol(input string nm, input logic [31:0] act, input int exp, input int tol);
    int d;
    n_chk++;
    d = int'(act) - exp;
    if (d < 0) d = -d;
    if (!$isunknown(act) && d <= tol) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h +/-%0d", nm, act, exp, tol);
  endtask

  // One request with out_ready low until the result appears, then a one-cycle handshake.
  task automatic transact(input logic [31:0] xv, output logic [31:0] o, output logic e,
                          output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk_eq("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x        = xv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = $urandom();
    lat      = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    o = out;
    e = domain_err;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_eq("release", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] o, ho, xv;
    logic        e;
    int          lat, w, a_cyc, p_cyc, exp_v;

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("rst_out", out, 32'd0);
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_domain_err", 32'(domain_err), 32'd0);
    chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    vt.push_back(mk("one",     32'h0001_0000));
    vt.push_back(mk("e",       32'h0002_B7E1));
    vt.push_back(mk("half",    32'h0000_8000));
    vt.push_back(mk("two",     32'h0002_0000));
    vt.push_back(mk("lsb",     32'h0000_0001));
    vt.push_back(mk("maxpos",  32'h7FFF_FFFF));
    vt.push_back(mk("zero",    32'h0000_0000));
    vt.push_back(mk("neg_one", 32'hFFFF_0000));
    vt.push_back(mk("minneg",  32'h8000_0000));
    vt.push_back(mk("after_err", 32'h0003_0000));

    foreach (vt[i]) begin
      transact(vt[i].xv, o, e, lat);
      chk_tol({vt[i].name, "_out"}, o, vt[i].exp_out, vt[i].tol);
      chk_eq({vt[i].name, "_err"}, 32'(e), 32'(vt[i].exp_err));
      chk_eq({vt[i].name, "_lat"}, 32'(lat), 32'(LAT));
    end

    // Backpressure: result held, new requests ignored while DONE.
    @(negedge clk);
    in_valid = 1'b1;
    x        = 32'h0003_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    ho = out;
    chk_tol("hold_value", ho, ref_ln(32'h0003_0000), TOL);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x        = $urandom();
      @(posedge clk);
      #1;
      chk_eq("hold_out", out, ho);
      chk_eq("hold_flags", {29'd0, out_valid, in_ready, domain_err}, 32'd4);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_eq("hold_release", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk);
    #1;
    chk_eq("hold_no_capture", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of the iteration phase.
    @(negedge clk);
    in_valid = 1'b1;
    x        = 32'h0005_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_eq("midrst_out", out, 32'd0);
    chk_eq("midrst_flags", {29'd0, out_valid, in_ready, domain_err}, 32'd2);
    @(negedge clk);
    reset_n = 1'b1;
    transact(32'h0002_0000, o, e, lat);
    chk_tol("postrst_out", o, ref_ln(32'h0002_0000), TOL);
    chk_eq("postrst_lat", 32'(lat), 32'(LAT));

    // Random positive sweep over all magnitudes.
    for (int r = 0; r < 40; r++) begin
      xv = ($urandom() >> $urandom_range(0, 31)) & 32'h7FFF_FFFF;
      if (xv == 0) xv = 32'd1;
      exp_v = ref_ln(xv);
      transact(xv, o, e, lat);
      chk_tol($sformatf("rand_%0d_x%08h", r, xv), o, exp_v, TOL);
      chk_eq($sformatf("rand_%0d_err", r), 32'(e), 32'd0);
    end

    // Back-to-back with out_ready held high: one accept every 20 cycles.
    out_ready = 1'b1;
    p_cyc = 0;
    @(posedge clk);
    #1;
    for (int j = 0; j < 6; j++) begin
      xv = ($urandom() >> $urandom_range(1, 20)) | 32'd1;
      w = 0;
      while (!in_ready && w < 64) begin
        @(posedge clk);
        #1;
        w++;
      end
      in_valid = 1'b1;
      x        = xv;
      @(posedge clk);
      #1;
      a_cyc    = cyc;
      in_valid = 1'b0;
      if (j > 0) chk_eq($sformatf("b2b_period_%0d", j), 32'(a_cyc - p_cyc), 32'd20);
      p_cyc = a_cyc;
      w = 0;
      while (!out_valid && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk_tol($sformatf("b2b_out_%0d", j), out, ref_ln(xv), TOL);
    end
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
